// File: rtl/trsq8_alu_pkg.sv
// Shared definitions for the multi-cycle ALU (alu_mc) and its iterative
// multiplier (alu_mul_seq).
//   - 5-bit opcode constants
//   - FSM state encoding (also driven out on the debug state port)
//   - helper that classifies the shift opcodes
package trsq8_alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b00010;
  localparam logic [4:0] OP_OR    = 5'b00011;
  localparam logic [4:0] OP_NOT   = 5'b00100;
  localparam logic [4:0] OP_XOR   = 5'b00101;
  localparam logic [4:0] OP_BS    = 5'b00110;
  localparam logic [4:0] OP_BC    = 5'b00111;
  localparam logic [4:0] OP_PASSA = 5'b01000;
  localparam logic [4:0] OP_PASSB = 5'b01001;
  localparam logic [4:0] OP_SHL   = 5'b01010;
  localparam logic [4:0] OP_SHR   = 5'b01011;
  localparam logic [4:0] OP_MUL   = 5'b01100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_FIN   = 2'd3
  } alu_state_t;

  function automatic logic is_shift(input logic [4:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bundle of the multi-cycle ALU.
//   master : requester (drives START/SEL/A/B/CF, observes BUSY/DONE/results)
//   slave  : the ALU
//
// Handshake: START_ip is a one-cycle request that is taken only while the
// ALU sits in IDLE (BUSY_op low and DONE_op low); SEL_ip, A_ip, B_ip and
// CF_ip are captured on that same edge. A request presented at any other
// time is dropped, not queued. DONE_op pulses for exactly one cycle when
// O_op/CF_op/ZF_op carry the new result; the result registers hold until
// the next DONE_op.
interface alu_mc_if #(
  parameter int WIDTH = 8
) ();

  logic             START_ip;
  logic [4:0]       SEL_ip;
  logic [WIDTH-1:0] A_ip;
  logic [WIDTH-1:0] B_ip;
  logic             CF_ip;
  logic             BUSY_op;
  logic             DONE_op;
  logic [WIDTH-1:0] O_op;
  logic             CF_op;
  logic             ZF_op;

  modport master (
    output START_ip, SEL_ip, A_ip, B_ip, CF_ip,
    input  BUSY_op, DONE_op, O_op, CF_op, ZF_op
  );

  modport slave (
    input  START_ip, SEL_ip, A_ip, B_ip, CF_ip,
    output BUSY_op, DONE_op, O_op, CF_op, ZF_op
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : load operands and begin (ignored bookkeeping: restarts)
//   a_i, b_i     : multiplicand / multiplier, sampled with start_i
//   done_o       : high during the final (WIDTH-th) iteration cycle
//   prod_o       : full 2*WIDTH-bit product, valid while done_o is high
// start_i at edge n -> done_o high in the cycle ending at edge n+WIDTH.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_nxt;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;

  // Accumulate the shifted multiplicand when the current multiplier LSB is 1.
  assign acc_nxt = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

  // The product is taken combinationally in the last iteration so the
  // caller can register it on the same edge that ends the iteration.
  assign done_o = run_q && (cnt_q == CW'(1));
  assign prod_o = acc_nxt;

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (start_i) begin
      acc_d   = '0;
      mcand_d = {{WIDTH{1'b0}}, a_i};
      mplr_d  = b_i;
      cnt_d   = CW'(WIDTH);
      run_d   = 1'b1;
    end else if (run_q) begin
      acc_d   = acc_nxt;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, bit-serial shifts and
// an iterative multiply, with registered result and flags.
// Ports:
//   CLK_ip, RST_ip : clock, synchronous active-high reset
//   bus (slave)    : START/SEL/A/B/CF request, BUSY/DONE/O/CF/ZF results
//   STATE_op       : current FSM state, for observation only
// Flow: IDLE accepts a request. Single-cycle ops and zero-count shifts go
// straight to FIN; non-zero shifts spend k cycles in SHIFT; MUL spends
// WIDTH cycles in MUL. FIN pulses DONE_op and always returns to IDLE.
module alu_mc
  import trsq8_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       CLK_ip,
  input  logic       RST_ip,
  alu_mc_if.slave    bus,
  output alu_state_t STATE_op
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             cf_q, cf_d;
  logic             zf_q, zf_d;
  logic             mc_q, mc_d;     // current op is multi-cycle
  logic [WIDTH-1:0] sh_q, sh_d;     // shift working register
  logic [SHW-1:0]   cnt_q, cnt_d;   // shifts still to perform
  logic             dir_q, dir_d;   // 1 = shift right

  logic [WIDTH:0]     alu_res;
  logic [WIDTH-1:0]   sh_nxt;
  logic               sh_out;
  logic [SHW-1:0]     k;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign k = bus.B_ip[SHW-1:0];

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk_i   (CLK_ip),
    .rst_i   (RST_ip),
    .start_i (mul_start),
    .a_i     (bus.A_ip),
    .b_i     (bus.B_ip),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // Single-cycle datapath; bit WIDTH is the carry/borrow.
  always_comb begin
    alu_res = '0;
    case (bus.SEL_ip)
      OP_ADD:   alu_res = {1'b0, bus.A_ip} + {1'b0, bus.B_ip} + {{WIDTH{1'b0}}, bus.CF_ip};
      OP_SUB:   alu_res = {1'b0, bus.A_ip} - {1'b0, bus.B_ip} + {{WIDTH{1'b0}}, bus.CF_ip};
      OP_AND:   alu_res = {1'b0, bus.A_ip & bus.B_ip};
      OP_OR:    alu_res = {1'b0, bus.A_ip | bus.B_ip};
      OP_NOT:   alu_res = {1'b0, ~bus.A_ip};
      OP_XOR:   alu_res = {1'b0, bus.A_ip ^ bus.B_ip};
      OP_BS:    alu_res = {1'b0, bus.A_ip & bus.B_ip};
      OP_BC:    alu_res = {1'b0, bus.A_ip & ~bus.B_ip};
      OP_PASSA: alu_res = {1'b0, bus.A_ip};
      OP_PASSB: alu_res = {1'b0, bus.B_ip};
      default:  alu_res = '0;  // undefined opcodes give a zero result
    endcase
  end

  // One-bit shift step; sh_out is the bit leaving the register.
  assign sh_nxt = dir_q ? {1'b0, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], 1'b0};
  assign sh_out = dir_q ? sh_q[0] : sh_q[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    o_d       = o_q;
    cf_d      = cf_q;
    zf_d      = zf_q;
    mc_d      = mc_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.START_ip) begin
          if (is_shift(bus.SEL_ip)) begin
            if (k == '0) begin
              // Zero shift count finishes like a single-cycle op.
              o_d     = bus.A_ip;
              cf_d    = 1'b0;
              zf_d    = (bus.A_ip == '0);
              mc_d    = 1'b0;
              state_d = ST_FIN;
            end else begin
              sh_d    = bus.A_ip;
              cnt_d   = k;
              dir_d   = (bus.SEL_ip == OP_SHR);
              mc_d    = 1'b1;
              state_d = ST_SHIFT;
            end
          end else if (bus.SEL_ip == OP_MUL) begin
            mul_start = 1'b1;
            mc_d      = 1'b1;
            state_d   = ST_MUL;
          end else begin
            o_d     = alu_res[WIDTH-1:0];
            cf_d    = alu_res[WIDTH];
            zf_d    = (alu_res[WIDTH-1:0] == '0);
            mc_d    = 1'b0;
            state_d = ST_FIN;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt_q == SHW'(1)) begin
          // Last shift: publish straight from the step so the working
          // register never shows on the outputs.
          o_d     = sh_nxt;
          cf_d    = sh_out;
          zf_d    = (sh_nxt == '0);
          state_d = ST_FIN;
        end else begin
          sh_d  = sh_nxt;
          cnt_d = cnt_q - SHW'(1);
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          o_d     = mul_prod[WIDTH-1:0];
          cf_d    = |mul_prod[2*WIDTH-1:WIDTH];
          zf_d    = (mul_prod[WIDTH-1:0] == '0);
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        // Any START seen here is dropped; acceptance only happens in IDLE.
        mc_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_ip) begin
    if (RST_ip) begin
      state_q <= ST_IDLE;
      o_q     <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b1;
      mc_q    <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
      mc_q    <= mc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // FIN of a single-cycle op does not count as busy.
  assign bus.BUSY_op = (state_q == ST_SHIFT) || (state_q == ST_MUL) ||
                       ((state_q == ST_FIN) && mc_q);
  assign bus.DONE_op = (state_q == ST_FIN);
  assign bus.O_op    = o_q;
  assign bus.CF_op   = cf_q;
  assign bus.ZF_op   = zf_q;
  assign STATE_op    = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=8. Latency is counted as the number of
// sample points (1 time unit after each rising edge) from the accepting edge
// up to and including the one where DONE_op is seen; a single-cycle op
// therefore shows latency 1.
module tb_alu_mc;
  import trsq8_alu_pkg::*;

  logic       clk;
  logic       rst;
  alu_state_t state_dbg;
  int         n_pass;
  int         n_total;

  alu_mc_if #(.WIDTH(8)) bus ();

  alu_mc #(.WIDTH(8)) dut (
    .CLK_ip   (clk),
    .RST_ip   (rst),
    .bus      (bus),
    .STATE_op (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Called just after an edge; returns just after the accepting edge.
  // Operands are scrambled afterwards so latching is exercised.
  task automatic drive_start(input logic [4:0] sel, input logic [7:0] a,
                             input logic [7:0] b, input logic cf);
    bus.SEL_ip   = sel;
    bus.A_ip     = a;
    bus.B_ip     = b;
    bus.CF_ip    = cf;
    bus.START_ip = 1'b1;
    @(posedge clk); #1;
    bus.START_ip = 1'b0;
    bus.A_ip     = ~a;
    bus.B_ip     = ~b;
    bus.CF_ip    = ~cf;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.DONE_op !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (bus.O_op !== 8'h00) $display("FAIL reset_o: got %h want 00", bus.O_op); else n_pass++;
    n_total++; if (bus.CF_op !== 1'b0) $display("FAIL reset_cf: got %b want 0", bus.CF_op); else n_pass++;
    n_total++; if (bus.ZF_op !== 1'b1) $display("FAIL reset_zf: got %b want 1", bus.ZF_op); else n_pass++;
    n_total++; if (bus.BUSY_op !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.BUSY_op); else n_pass++;
    n_total++; if (bus.DONE_op !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.DONE_op); else n_pass++;
    n_total++; if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d want 0", state_dbg); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    drive_start(OP_ADD, 8'hFF, 8'h01, 1'b0);
    wait_done(lat);
    n_total++; if (lat !== 1) $display("FAIL add_ovf_lat: got %0d want 1", lat); else n_pass++;
    n_total++; if (bus.O_op !== 8'h00) $display("FAIL add_ovf_o: got %h want 00", bus.O_op); else n_pass++;
    n_total++; if (bus.CF_op !== 1'b1) $display("FAIL add_ovf_cf: got %b want 1", bus.CF_op); else n_pass++;
    n_total++; if (bus.ZF_op !== 1'b1) $display("FAIL add_ovf_zf: got %b want 1", bus.ZF_op); else n_pass++;
    n_total++; if (bus.BUSY_op !== 1'b0) $display("FAIL add_busy: got %b want 0", bus.BUSY_op); else n_pass++;
    @(posedge clk); #1;
    drive_start(OP_ADD, 8'h12, 8'h34, 1'b1);
    wait_done(lat);
    n_total++; if (bus.O_op !== 8'h47) $display("FAIL add_cin_o: got %h want 47", bus.O_op); else n_pass++;
    n_total++; if (bus.CF_op !== 1'b0) $display("FAIL add_cin_cf: got %b want 0", bus.CF_op); else n_pass++;
    n_total++; if (bus.ZF_op !== 1'b0) $display("FAIL add_cin_zf: got %b want 0", bus.ZF_op); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.DONE_op !== 1'b0) $display("FAIL add_done_pulse: got %b want 0", bus.DONE_op); else n_pass++;
    n_total++; if (bus.O_op !== 8'h47) $display("FAIL add_hold_o: got %h want 47", bus.O_op); else n_pass++;
  endtask

  task automatic test_sub();
    int lat;
    drive_start(OP_SUB, 8'h03, 8'h05, 1'b0);
    wait_done(lat);
    n_total++; if (lat !== 1) $display("FAIL sub_lat: got %0d want 1", lat); else n_pass++;
    n_total++; if (bus.O_op !== 8'hFE) $display("FAIL sub_borrow_o: got %h want FE", bus.O_op); else n_pass++;
    n_total++; if (bus.CF_op !== 1'b1) $display("FAIL sub_borrow_cf: got %b want 1", bus.CF_op); else n_pass++;
    n_total++; if (bus.ZF_op !== 1'b0) $display("FAIL sub_borrow_zf: got %b want 0", bus.ZF_op); else n_pass++;
    @(posedge clk); #1;
    drive_start(OP_SUB, 8'h05, 8'h03, 1'b0);
    wait_done(lat);
    n_total++; if (bus.O_op !== 8'h02) $display("FAIL sub_pos_o: got %h want 02", bus.O_op); else n_pass++;
    n_total++; if (bus.CF_op !== 1'b0) $display("FAIL sub_pos_cf: got %b want 0", bus.CF_op); else n_pass++;
    @(posedge clk); #1;
    drive_start(OP_SUB, 8'h05, 8'h05, 1'b1);
    wait_done(lat);
    n_total++; if (bus.O_op !== 8'h01) $display("FAIL sub_cin_o: got %h want 01", bus.O_op); else n_pass++;
    n_total++; if (bus.CF_op !== 1'b0) $display("FAIL sub_cin_cf: got %b want 0", bus.CF_op); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_logic();
    logic [4:0] sels [8];
    logic [7:0] exps [8];
    int lat;
    sels = '{OP_AND, OP_OR, OP_NOT, OP_XOR, OP_BS, OP_BC, OP_PASSA, OP_PASSB};
    exps = '{8'h30, 8'hFC, 8'h0F, 8'hCC, 8'h30, 8'hC0, 8'hF0, 8'h3C};
    for (int i = 0; i < 8; i++) begin
      // Set CF first so a cleared CF is a real observation.
      drive_start(OP_ADD, 8'hFF, 8'h02, 1'b0);
      wait_done(lat);
      @(posedge clk); #1;
      drive_start(sels[i], 8'hF0, 8'h3C, 1'b1);
      wait_done(lat);
      n_total++; if (bus.O_op !== exps[i]) $display("FAIL logic_o[%0d]: got %h want %h", i, bus.O_op, exps[i]); else n_pass++;
      n_total++; if (bus.CF_op !== 1'b0) $display("FAIL logic_cf[%0d]: got %b want 0", i, bus.CF_op); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_shift();
    int lat;
    drive_start(OP_PASSA, 8'h77, 8'h00, 1'b0);
    wait_done(lat);
    @(posedge clk); #1;
    drive_start(OP_SHL, 8'h81, 8'h03, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      n_total++; if (bus.BUSY_op !== 1'b1) $display("FAIL shl_busy[%0d]: got %b want 1", i, bus.BUSY_op); else n_pass++;
      n_total++; if (bus.DONE_op !== 1'b0) $display("FAIL shl_early_done[%0d]: got %b want 0", i, bus.DONE_op); else n_pass++;
      n_total++; if (bus.O_op !== 8'h77) $display("FAIL shl_hold_o[%0d]: got %h want 77", i, bus.O_op); else n_pass++;
      @(posedge clk); #1;
    end
    n_total++; if (bus.DONE_op !== 1'b1) $display("FAIL shl_done_c4: got %b want 1", bus.DONE_op); else n_pass++;
    n_total++; if (bus.O_op !== 8'h08) $display("FAIL shl_o: got %h want 08", bus.O_op); else n_pass++;
    n_total++; if (bus.CF_op !== 1'b0) $display("FAIL shl_cf: got %b want 0", bus.CF_op); else n_pass++;
    @(posedge clk); #1;
    drive_start(OP_SHR, 8'h81, 8'h01, 1'b0);
    wait_done(lat);
    n_total++; if (lat !== 2) $display("FAIL shr_lat: got %0d want 2", lat); else n_pass++;
    n_total++; if (bus.O_op !== 8'h40) $display("FAIL shr_o: got %h want 40", bus.O_op); else n_pass++;
    n_total++; if (bus.CF_op !== 1'b1) $display("FAIL shr_cf: got %b want 1", bus.CF_op); else n_pass++;
    @(posedge clk); #1;
    drive_start(OP_SHL, 8'h5A, 8'h08, 1'b0);   // count field B[2:0] = 0
    wait_done(lat);
    n_total++; if (lat !== 1) $display("FAIL shl_k0_lat: got %0d want 1", lat); else n_pass++;
    n_total++; if (bus.O_op !== 8'h5A) $display("FAIL shl_k0_o: got %h want 5A", bus.O_op); else n_pass++;
    n_total++; if (bus.CF_op !== 1'b0) $display("FAIL shl_k0_cf: got %b want 0", bus.CF_op); else n_pass++;
    n_total++; if (bus.BUSY_op !== 1'b0) $display("FAIL shl_k0_busy: got %b want 0", bus.BUSY_op); else n_pass++;
    @(posedge clk); #1;
    drive_start(OP_SHR, 8'h01, 8'h01, 1'b0);
    wait_done(lat);
    n_total++; if (bus.O_op !== 8'h00) $display("FAIL shr_zero_o: got %h want 00", bus.O_op); else n_pass++;
    n_total++; if (bus.ZF_op !== 1'b1) $display("FAIL shr_zero_zf: got %b want 1", bus.ZF_op); else n_pass++;
    n_total++; if (bus.CF_op !== 1'b1) $display("FAIL shr_zero_cf: got %b want 1", bus.CF_op); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int lat;
    drive_start(OP_MUL, 8'h0F, 8'h0B, 1'b0);
    wait_done(lat);
    n_total++; if (lat !== 9) $display("FAIL mul_a5_lat: got %0d want 9", lat); else n_pass++;
    n_total++; if (bus.O_op !== 8'hA5) $display("FAIL mul_a5_o: got %h want A5", bus.O_op); else n_pass++;
    n_total++; if (bus.CF_op !== 1'b0) $display("FAIL mul_a5_cf: got %b want 0", bus.CF_op); else n_pass++;
    @(posedge clk); #1;
    drive_start(OP_MUL, 8'h10, 8'h20, 1'b0);
    n_total++; if (bus.BUSY_op !== 1'b1) $display("FAIL mul_busy: got %b want 1", bus.BUSY_op); else n_pass++;
    // Request while busy: must be dropped.
    bus.SEL_ip = OP_ADD; bus.A_ip = 8'h01; bus.B_ip = 8'h01; bus.CF_ip = 1'b0;
    bus.START_ip = 1'b1;
    @(posedge clk); #1;
    bus.START_ip = 1'b0;
    n_total++; if (bus.O_op !== 8'hA5) $display("FAIL mul_hold_o: got %h want A5", bus.O_op); else n_pass++;
    wait_done(lat);
    lat = lat + 1;
    n_total++; if (lat !== 9) $display("FAIL mul_lat: got %0d want 9", lat); else n_pass++;
    n_total++; if (bus.O_op !== 8'h00) $display("FAIL mul_o: got %h want 00", bus.O_op); else n_pass++;
    n_total++; if (bus.CF_op !== 1'b1) $display("FAIL mul_cf: got %b want 1", bus.CF_op); else n_pass++;
    n_total++; if (bus.ZF_op !== 1'b1) $display("FAIL mul_zf: got %b want 1", bus.ZF_op); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.BUSY_op !== 1'b0) $display("FAIL mul_idle_busy: got %b want 0", bus.BUSY_op); else n_pass++;
    n_total++; if (bus.O_op !== 8'h00) $display("FAIL mul_after_o: got %h want 00", bus.O_op); else n_pass++;
  endtask

  task automatic test_mul_reset();
    int lat;
    logic seen_done;
    drive_start(OP_ADD, 8'hFF, 8'h02, 1'b0);   // leaves O=01, CF=1
    wait_done(lat);
    @(posedge clk); #1;
    drive_start(OP_MUL, 8'h0F, 8'h0B, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    // Reset in cycle 4, together with a START that must lose.
    rst = 1'b1;
    bus.SEL_ip = OP_ADD; bus.A_ip = 8'h10; bus.B_ip = 8'h10; bus.CF_ip = 1'b0;
    bus.START_ip = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.START_ip = 1'b0;
    n_total++; if (bus.O_op !== 8'h00) $display("FAIL rst_mul_o: got %h want 00", bus.O_op); else n_pass++;
    n_total++; if (bus.CF_op !== 1'b0) $display("FAIL rst_mul_cf: got %b want 0", bus.CF_op); else n_pass++;
    n_total++; if (bus.ZF_op !== 1'b1) $display("FAIL rst_mul_zf: got %b want 1", bus.ZF_op); else n_pass++;
    n_total++; if (bus.BUSY_op !== 1'b0) $display("FAIL rst_mul_busy: got %b want 0", bus.BUSY_op); else n_pass++;
    seen_done = bus.DONE_op;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.DONE_op === 1'b1) seen_done = 1'b1;
    end
    n_total++; if (seen_done !== 1'b0) $display("FAIL rst_mul_no_done: got %b want 0", seen_done); else n_pass++;
    drive_start(OP_ADD, 8'h01, 8'h01, 1'b0);
    wait_done(lat);
    n_total++; if (lat !== 1) $display("FAIL rst_add_lat: got %0d want 1", lat); else n_pass++;
    n_total++; if (bus.O_op !== 8'h02) $display("FAIL rst_add_o: got %h want 02", bus.O_op); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_undef();
    int lat;
    drive_start(OP_ADD, 8'hFF, 8'h02, 1'b0);   // O=01, CF=1, ZF=0
    wait_done(lat);
    @(posedge clk); #1;
    drive_start(5'b11111, 8'h55, 8'h00, 1'b1);
    wait_done(lat);
    n_total++; if (lat !== 1) $display("FAIL undef_lat: got %0d want 1", lat); else n_pass++;
    n_total++; if (bus.O_op !== 8'h00) $display("FAIL undef_o: got %h want 00", bus.O_op); else n_pass++;
    n_total++; if (bus.ZF_op !== 1'b1) $display("FAIL undef_zf: got %b want 1", bus.ZF_op); else n_pass++;
    n_total++; if (bus.CF_op !== 1'b0) $display("FAIL undef_cf: got %b want 0", bus.CF_op); else n_pass++;
    @(posedge clk); #1;
    drive_start(OP_PASSA, 8'h3C, 8'h00, 1'b0);
    wait_done(lat);
    @(posedge clk); #1;
    drive_start(5'b01101, 8'hAA, 8'h55, 1'b1);
    wait_done(lat);
    n_total++; if (bus.O_op !== 8'h00) $display("FAIL undef2_o: got %h want 00", bus.O_op); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    drive_start(OP_SHL, 8'h01, 8'h01, 1'b0);
    wait_done(lat);
    n_total++; if (lat !== 2) $display("FAIL b2b_shl_lat: got %0d want 2", lat); else n_pass++;
    // START during the FIN cycle: must be ignored.
    bus.SEL_ip = OP_ADD; bus.A_ip = 8'h10; bus.B_ip = 8'h10; bus.CF_ip = 1'b0;
    bus.START_ip = 1'b1;
    @(posedge clk); #1;
    bus.START_ip = 1'b0;
    n_total++; if (bus.DONE_op !== 1'b0) $display("FAIL b2b_fin_done: got %b want 0", bus.DONE_op); else n_pass++;
    n_total++; if (bus.O_op !== 8'h02) $display("FAIL b2b_fin_o: got %h want 02", bus.O_op); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.DONE_op !== 1'b0) $display("FAIL b2b_late_done: got %b want 0", bus.DONE_op); else n_pass++;
    drive_start(OP_ADD, 8'h10, 8'h10, 1'b0);
    wait_done(lat);
    n_total++; if (bus.O_op !== 8'h20) $display("FAIL b2b_add_o: got %h want 20", bus.O_op); else n_pass++;
    @(posedge clk); #1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_pass       = 0;
    n_total      = 0;
    rst          = 1'b1;
    bus.START_ip = 1'b0;
    bus.SEL_ip   = 5'b0;
    bus.A_ip     = 8'h00;
    bus.B_ip     = 8'h00;
    bus.CF_ip    = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_mul();
    test_mul_reset();
    test_undef();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
